unary_stream_decoder: RTL and testbench

- Receive side of the temporal-unary lane interface. Converts per-lane pulse streams back to binary.
- Each lane carries a value v as a stream over a fixed window of 2^SIZE-1 cycles, with 1s in the first v cycles and 0s after.
- Counts 1s per lane, flags lanes whose stream is not thermometer-shaped, and produces the cross-lane sum.
- Presents the result on a valid/ready handshake to downstream accumulation or checking logic.

---
 rtl/unary_stream_decoder.sv | 143 ++++++++++++++
 tb/tb_unary_stream_decoder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/unary_stream_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : unary_stream_decoder
//  Description : Receive side of a temporal-unary lane interface. Counts the
//                1s on each lane over a fixed window of 2^SIZE-1 cycles,
//                flags lanes whose stream is not thermometer-shaped, forms
//                the cross-lane sum and presents the result on valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module unary_stream_decoder #(
    parameter int SIZE = 4,
    parameter int SETS = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [SETS-1:0]                in_unary,
    output logic                           busy,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [SETS*SIZE-1:0]           out_value,
    output logic [SETS-1:0]                out_error,
    output logic [SIZE+$clog2(SETS)-1:0]   out_sum
);

    localparam int              W      = (1 << SIZE) - 1;
    localparam int              SUM_W  = SIZE + $clog2(SETS);
    localparam logic [SIZE-1:0] C_LAST = SIZE'(W - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [SIZE-1:0]        cyc_q, cyc_d;
    logic [SETS*SIZE-1:0]   cnt_q, cnt_d;
    logic [SETS-1:0]        seen_zero_q, seen_zero_d;
    logic [SETS-1:0]        err_q, err_d;
    logic                   load_out;
    logic [SUM_W-1:0]       sum_d;

    logic [SETS*SIZE-1:0]   out_value_q;
    logic [SETS-1:0]        out_error_q;
    logic [SUM_W-1:0]       out_sum_q;

    // Next-state, per-lane counting and result-capture control.
    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        cnt_d       = cnt_q;
        seen_zero_d = seen_zero_q;
        err_d       = err_q;
        load_out    = 1'b0;

        case (state_q)
            IDLE: begin
                cyc_d       = '0;
                cnt_d       = '0;
                seen_zero_d = '0;
                err_d       = '0;
                if (start) begin
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                cyc_d = cyc_q + 1'b1;
                for (int j = 0; j < SETS; j++) begin
                    if (in_unary[j]) begin
                        // Every 1 is counted, even one arriving after a 0.
                        cnt_d[j*SIZE +: SIZE] = cnt_q[j*SIZE +: SIZE] + 1'b1;
                        if (seen_zero_q[j]) begin
                            err_d[j] = 1'b1;
                        end
                    end else begin
                        seen_zero_d[j] = 1'b1;
                    end
                end
                // The final sample is folded in via the _d values captured below.
                if (cyc_q == C_LAST) begin
                    state_d  = HOLD;
                    load_out = 1'b1;
                end
            end
            HOLD: begin
                // Working state is cleared so a back-to-back window starts clean;
                // the presented result lives in the out_*_q registers.
                cyc_d       = '0;
                cnt_d       = '0;
                seen_zero_d = '0;
                err_d       = '0;
                if (out_ready) begin
                    state_d = start ? COLLECT : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Cross-lane sum of the final (post-last-sample) lane counts.
    always_comb begin
        sum_d = '0;
        for (int j = 0; j < SETS; j++) begin
            sum_d = sum_d + SUM_W'(cnt_d[j*SIZE +: SIZE]);
        end
    end

    // State, working counters and held result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cyc_q       <= '0;
            cnt_q       <= '0;
            seen_zero_q <= '0;
            err_q       <= '0;
            out_value_q <= '0;
            out_error_q <= '0;
            out_sum_q   <= '0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            cnt_q       <= cnt_d;
            seen_zero_q <= seen_zero_d;
            err_q       <= err_d;
            if (load_out) begin
                out_value_q <= cnt_d;
                out_error_q <= err_d;
                out_sum_q   <= sum_d;
            end
        end
    end

    assign busy      = (state_q == COLLECT);
    assign out_valid = (state_q == HOLD);
    assign out_value = out_value_q;
    assign out_error = out_error_q;
    assign out_sum   = out_sum_q;

endmodule
`default_nettype wire

// File: tb/tb_unary_stream_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_unary_stream_decoder
//  Description : Directed self-checking bench for unary_stream_decoder
//                (SIZE=4, SETS=2, window of 15 cycles).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_unary_stream_decoder;

    localparam int SIZE = 4;
    localparam int SETS = 2;
    localparam int W    = 15;

    logic       clk;
    logic       reset;
    logic       start;
    logic [1:0] in_unary;
    logic       busy;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_value;
    logic [1:0] out_error;
    logic [4:0] out_sum;

    int vectors;
    int miscompares;

    unary_stream_decoder #(.SIZE(SIZE), .SETS(SETS)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_unary  (in_unary),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_value (out_value),
        .out_error (out_error),
        .out_sum   (out_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one edge from IDLE.
    task automatic start_window();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Drive a full window; bit i of each pattern is the sample for cycle i.
    task automatic feed(input logic [14:0] l0, input logic [14:0] l1, input logic hold_start);
        for (int i = 0; i < W; i++) begin
            in_unary = {l1[i], l0[i]};
            start    = hold_start;
            tick();
        end
        in_unary = 2'b00;
        start    = 1'b0;
    endtask

    task automatic accept();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL accept_valid_drop: got %b expected 0", out_valid);
        end
    endtask

    task automatic check_result(input string name, input logic [7:0] v,
                                input logic [1:0] e, input logic [4:0] s);
        vectors++;
        if (out_valid !== 1'b1 || busy !== 1'b0 || out_value !== v ||
            out_error !== e || out_sum !== s) begin
            miscompares++;
            $display("FAIL %s: got valid=%b busy=%b value=%h err=%b sum=%0d expected valid=1 busy=0 value=%h err=%b sum=%0d",
                     name, out_valid, busy, out_value, out_error, out_sum, v, e, s);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        vectors++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || out_value !== 8'h00 ||
            out_error !== 2'b00 || out_sum !== 5'd0) begin
            miscompares++;
            $display("FAIL reset_state: got busy=%b valid=%b value=%h err=%b sum=%0d expected all 0",
                     busy, out_valid, out_value, out_error, out_sum);
        end
        // Reset and start together: reset wins, start not remembered.
        reset = 1'b1;
        start = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        tick();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_with_start: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_latency_basic();
        logic [14:0] l0;
        logic [14:0] l1;
        l0 = 15'h001F;
        l1 = 15'h7FFF;
        start_window();
        for (int i = 0; i < W; i++) begin
            vectors++;
            if (busy !== 1'b1 || out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL collect_cycle%0d: got busy=%b valid=%b expected busy=1 valid=0",
                         i, busy, out_valid);
            end
            in_unary = {l1[i], l0[i]};
            tick();
        end
        in_unary = 2'b00;
        check_result("basic_5_15", 8'hF5, 2'b00, 5'd20);
        accept();
    endtask

    task automatic test_zero_ones();
        start_window();
        feed(15'h0000, 15'h0000, 1'b0);
        check_result("all_zero", 8'h00, 2'b00, 5'd0);
        accept();
        start_window();
        feed(15'h7FFF, 15'h7FFF, 1'b0);
        check_result("all_ones", 8'hFF, 2'b00, 5'd30);
        accept();
    endtask

    task automatic test_error();
        start_window();
        feed(15'h000B, 15'h0002, 1'b0);
        check_result("non_thermometer", 8'h13, 2'b11, 5'd4);
        accept();
    endtask

    task automatic test_backpressure();
        start_window();
        feed(15'h0007, 15'h0001, 1'b0);
        check_result("bp_first", 8'h13, 2'b00, 5'd4);
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            start = i[0] ? 1'b0 : 1'b1;
            tick();
            vectors++;
            if (out_valid !== 1'b1 || busy !== 1'b0 || out_value !== 8'h13 ||
                out_sum !== 5'd4) begin
                miscompares++;
                $display("FAIL bp_hold%0d: got valid=%b busy=%b value=%h sum=%0d expected valid=1 busy=0 value=13 sum=4",
                         i, out_valid, busy, out_value, out_sum);
            end
        end
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        vectors++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_restart: got busy=%b valid=%b expected busy=1 valid=0", busy, out_valid);
        end
        feed(15'h007F, 15'h0000, 1'b0);
        check_result("b2b_second", 8'h07, 2'b00, 5'd7);
        accept();
    endtask

    task automatic test_start_during_collect();
        start_window();
        feed(15'h000F, 15'h0003, 1'b1);
        check_result("start_held", 8'h24, 2'b00, 5'd6);
        tick();
        tick();
        vectors++;
        if (out_valid !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL start_held_stay: got valid=%b busy=%b expected valid=1 busy=0", out_valid, busy);
        end
        accept();
        tick();
        vectors++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL no_restart: got busy=%b valid=%b expected 0 0", busy, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        start_window();
        for (int i = 0; i < 8; i++) begin
            in_unary = 2'b11;
            tick();
        end
        in_unary = 2'b00;
        reset    = 1'b1;
        tick();
        reset    = 1'b0;
        vectors++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || out_value !== 8'h00 || out_sum !== 5'd0) begin
            miscompares++;
            $display("FAIL reset_mid: got busy=%b valid=%b value=%h sum=%0d expected 0 0 00 0",
                     busy, out_valid, out_value, out_sum);
        end
        tick();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_idle: got busy=%b expected 0", busy);
        end
        start_window();
        feed(15'h01FF, 15'h0000, 1'b0);
        check_result("after_reset", 8'h09, 2'b00, 5'd9);
        accept();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        start       = 1'b0;
        in_unary    = 2'b00;
        out_ready   = 1'b0;
        #1;
        test_reset();
        test_latency_basic();
        test_zero_ones();
        test_error();
        test_backpressure();
        test_start_during_collect();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
